bbox_tracker: RTL



---
 rtl/bbox_pkg.sv | 27 ++
 rtl/frame_xy_counter.sv | 64 ++++++
 rtl/bbox_tracker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bbox_pkg
// Description : Shared types, RGB565 colours and edge helpers for bbox_tracker.
// Revision    : 1.0  initial release
// ============================================================================
package bbox_pkg;

    localparam int C_COORD_W = 12;

    typedef logic [C_COORD_W-1:0] coord_t;
    typedef logic [15:0]          rgb565_t;

    localparam rgb565_t C_RGB565_RED   = 16'hF800;
    localparam rgb565_t C_RGB565_GREEN = 16'h07E0;
    localparam rgb565_t C_RGB565_WHITE = 16'hFFFF;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic fall_edge(input logic cur, input logic prev);
        return ~cur & prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_xy_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_xy_counter
// Description : vsync/href edge detection and saturating x/y pixel position.
// Revision    : 1.0  initial release
// ============================================================================
module frame_xy_counter
    import bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic          clken,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          vs_rise,
    output logic          href_fall,
    output logic          in_active
);

    localparam logic [CW-1:0] C_X_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_Y_LAST = CW'(IMG_H - 1);

    logic          r_vsync_d1;
    logic          r_href_d1;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    assign vs_rise   = rise_edge(vsync, r_vsync_d1);
    assign href_fall = fall_edge(href, r_href_d1);
    assign in_active = clken & href;
    assign x         = r_x;
    assign y         = r_y;

    // x/y hold the position of the pixel currently on the input bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d1 <= 1'b0;
            r_href_d1  <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_vsync_d1 <= vsync;
            r_href_d1  <= href;

            if (vs_rise || href_fall)
                r_x <= '0;
            else if (in_active && (r_x != C_X_LAST))
                r_x <= r_x + 1'b1;

            if (vs_rise)
                r_y <= '0;
            else if (href_fall && (r_y != C_Y_LAST))
                r_y <= r_y + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bbox_tracker
// Description : Per-frame foreground bounding box with threshold and overlay.
// Revision    : 1.0  initial release
// ============================================================================
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int          IMG_W     = 640,
    parameter int          IMG_H     = 480,
    parameter int          CW        = 12,
    parameter int          PCW       = 20,
    parameter int          MIN_PIX   = 64,
    parameter logic [15:0] BOX_COLOR = 16'hF800
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           per_frame_vsync,
    input  logic           per_frame_href,
    input  logic           per_frame_clken,
    input  logic           per_img_bit,
    output logic           post_frame_vsync,
    output logic           post_frame_href,
    output logic           post_frame_clken,
    output logic [15:0]    post_img,
    output logic [CW-1:0]  x_min,
    output logic [CW-1:0]  x_max,
    output logic [CW-1:0]  y_min,
    output logic [CW-1:0]  y_max,
    output logic [PCW-1:0] pix_cnt,
    output logic           box_valid,
    output logic           frame_done
);

    localparam logic [CW-1:0]  C_X_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]  C_Y_LAST  = CW'(IMG_H - 1);
    localparam logic [PCW-1:0] C_CNT_MAX = '1;
    localparam logic [PCW-1:0] C_MIN_PIX = PCW'(MIN_PIX);

    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic          w_vs_rise;
    logic          w_href_fall;
    logic          w_in_active;
    logic          w_fg;
    logic          w_x_in;
    logic          w_y_in;
    logic          w_on_perim;

    logic [CW-1:0]  r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    logic [PCW-1:0] r_acc_cnt;
    logic [CW-1:0]  r_x_min, r_x_max, r_y_min, r_y_max;
    logic [PCW-1:0] r_pix_cnt;
    logic           r_box_valid;
    logic           r_frame_done;
    logic           r_post_vsync, r_post_href, r_post_clken;
    rgb565_t        r_post_img;

    frame_xy_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_xy (
        .clk       (clk),
        .rst       (rst),
        .vsync     (per_frame_vsync),
        .href      (per_frame_href),
        .clken     (per_frame_clken),
        .x         (w_x),
        .y         (w_y),
        .vs_rise   (w_vs_rise),
        .href_fall (w_href_fall),
        .in_active (w_in_active)
    );

    // A foreground pixel landing on the frame boundary belongs to blanking.
    assign w_fg       = w_in_active & per_img_bit & ~w_vs_rise;
    assign w_x_in     = (w_x >= r_x_min) && (w_x <= r_x_max);
    assign w_y_in     = (w_y >= r_y_min) && (w_y <= r_y_max);
    assign w_on_perim = (((w_x == r_x_min) || (w_x == r_x_max)) && w_y_in) ||
                        (((w_y == r_y_min) || (w_y == r_y_max)) && w_x_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_xmin   <= C_X_LAST;
            r_acc_xmax   <= '0;
            r_acc_ymin   <= C_Y_LAST;
            r_acc_ymax   <= '0;
            r_acc_cnt    <= '0;
            r_x_min      <= C_X_LAST;
            r_x_max      <= '0;
            r_y_min      <= C_Y_LAST;
            r_y_max      <= '0;
            r_pix_cnt    <= '0;
            r_box_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_vs_rise;
            if (w_vs_rise) begin
                r_pix_cnt <= r_acc_cnt;
                if (r_acc_cnt >= C_MIN_PIX) begin
                    r_x_min     <= r_acc_xmin;
                    r_x_max     <= r_acc_xmax;
                    r_y_min     <= r_acc_ymin;
                    r_y_max     <= r_acc_ymax;
                    r_box_valid <= 1'b1;
                end else begin
                    r_box_valid <= 1'b0;
                end
                r_acc_xmin <= C_X_LAST;
                r_acc_xmax <= '0;
                r_acc_ymin <= C_Y_LAST;
                r_acc_ymax <= '0;
                r_acc_cnt  <= '0;
            end else if (w_fg) begin
                if (w_x < r_acc_xmin) r_acc_xmin <= w_x;
                if (w_x > r_acc_xmax) r_acc_xmax <= w_x;
                if (w_y < r_acc_ymin) r_acc_ymin <= w_y;
                if (w_y > r_acc_ymax) r_acc_ymax <= w_y;
                if (r_acc_cnt != C_CNT_MAX) r_acc_cnt <= r_acc_cnt + 1'b1;
            end
        end
    end

    // The overlay always compares against the box latched at the previous boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_vsync <= 1'b0;
            r_post_href  <= 1'b0;
            r_post_clken <= 1'b0;
            r_post_img   <= '0;
        end else begin
            r_post_vsync <= per_frame_vsync;
            r_post_href  <= per_frame_href;
            r_post_clken <= per_frame_clken;
            if (r_box_valid && w_in_active && w_on_perim)
                r_post_img <= BOX_COLOR;
            else if (per_frame_href)
                r_post_img <= {16{per_img_bit}};
            else
                r_post_img <= '0;
        end
    end

    assign post_frame_vsync = r_post_vsync;
    assign post_frame_href  = r_post_href;
    assign post_frame_clken = r_post_clken;
    assign post_img         = r_post_img;
    assign x_min            = r_x_min;
    assign x_max            = r_x_max;
    assign y_min            = r_y_min;
    assign y_max            = r_y_max;
    assign pix_cnt          = r_pix_cnt;
    assign box_valid        = r_box_valid;
    assign frame_done       = r_frame_done;

endmodule
`default_nettype wire
